instr_encoder_loader: RTL
=========================

# instr_encoder_loader

Sequential MIPS instruction encoder and instruction-memory loader. Accepts one instruction per handshake as symbolic fields (kind, registers, immediate, jump target) and packs them into 32-bit MIPS words. Writes the packed words to consecutive instruction-memory addresses through a registered write port. It is the encoding counterpart of the CPU's opcode control decoder, and is used by the test/boot path to fill instruction memory before the core is released.

## Interface
- ADDR_W, 8: instruction-memory word-address width.
- DEPTH, 256: number of words to fill; must satisfy 1 <= DEPTH <= 2^ADDR_W.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a load session; honoured only in IDLE or DONE.
- finish  in  1  single-cycle pulse that ends the session early; honoured only in LOAD.
- in_valid  in  1  source presents an instruction.
- in_ready  out  1  block can accept an instruction; high only in LOAD with word_count < DEPTH.
- in_kind  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 LW, 6 SW, 7 BEQ, 8 ORI, 9 J; 10–15 are illegal.
- in_rs, in_rt, in_rd  in  5 each  register fields.
- in_imm  in  16  immediate/offset.
- in_target  in  26  jump target.
- mem_we  out  1  instruction-memory write strobe.
- mem_addr  out  ADDR_W  write word address.
- mem_wdata  out  32  encoded word.
- word_count  out  ADDR_W+1  words written this session.
- busy  out  1  high in LOAD or PAD.
- done  out  1  high in DONE.
- err_illegal  out  1  sticky; set on any accepted illegal kind; cleared by start.

## Operation
- FSM states: IDLE, LOAD, PAD, DONE. Reset enters IDLE.
- IDLE/DONE + start: go to LOAD. Clear word_count and err_illegal.
- LOAD:
  - An accept occurs when in_valid & in_ready at a rising edge.
  - A legal accept writes a word at address word_count, then increments word_count.
  - An illegal accept completes the handshake but produces no write and no increment. It sets err_illegal.
- Encodings:
  - R-type: {6'b000000, rs, rt, rd, 5'b00000, funct}. funct is ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010.
  - LW: {100011, rs, rt, imm}.
  - SW: {101011, rs, rt, imm}.
  - BEQ: {000100, rs, rt, imm}.
  - ORI: {001101, rs, rt, imm}.
  - J: {000010, target}.
  - Unused fields are ignored.
- Full condition: when word_count reaches DEPTH, in_ready drops and the FSM goes to DONE on the same edge as the last write.
- finish in LOAD: go to PAD (macro defined) or DONE (macro undefined).
  - If finish coincides with an accept, that word is still written first.
- start in LOAD or PAD is ignored. finish outside LOAD is ignored.
- Reset mid-session aborts immediately. Partial memory contents are left as written.

## Timing
- Reset values: in_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, word_count 0, busy 0, done 0, err_illegal 0.
- Write latency is 1 cycle. An accept at edge N drives mem_we/mem_addr/mem_wdata as registered outputs valid from edge N to edge N+1.
- mem_we is high for exactly one cycle per written word. word_count updates on the same edge as the write outputs.
- in_ready is registered/state-derived and never combinationally depends on in_valid.
- Throughput: one instruction per cycle while in_valid stays high.
- in_ready goes high the cycle after start is sampled.
- done rises on the edge that completes the final write, or on the edge after finish (no-pad case).

## Configuration
- ENCODER_NOP_PAD_EN defined:
  - PAD writes NOP (32'h00000000) once per cycle at address word_count, incrementing until word_count == DEPTH, then enters DONE.
  - in_ready is 0 in PAD.
  - If finish arrives with word_count already DEPTH, go directly to DONE.
- ENCODER_NOP_PAD_EN undefined:
  - The PAD state is not built. finish goes straight to DONE.
  - Unwritten locations are untouched.

## Test plan
- Reset, start, then send ADD rs=1 rt=2 rd=3 -> mem_we one cycle, addr 0, wdata 32'h00221820; word_count 1.
- Back-to-back LW rs=0 rt=8 imm=4, SW rs=0 rt=8 imm=8, BEQ rs=8 rt=9 imm=16'hFFFF, ORI rs=0 rt=1 imm=16'h00FF, J target=26'h0000010 -> wdata 8C080004, AC080008, 1109FFFF, 340100FF, 08000010 at addrs 0–4 on consecutive cycles.
- in_kind 12 accepted between two ORIs -> err_illegal set, the two ORIs land at addrs 0 and 1, and no gap; a new start clears err_illegal.
- DEPTH=4, send 5 words with in_valid held -> 4 writes, in_ready low after the 4th, done high, 5th word never accepted.
- DEPTH=8, with macro: 3 words, then finish -> NOPs written at addrs 3–7 on 5 consecutive cycles, then done. Without macro: done one cycle after finish, no further writes.
- Assert reset mid-LOAD after 2 writes -> all outputs 0 immediately (asynchronously); next start resumes at addr 0.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// MIPS instruction encoder that packs symbolic fields into 32-bit words and streams them into instruction memory.
// Optional NOP padding of the unwritten tail after an early finish is enabled by defining ENCODER_NOP_PAD_EN.
module instr_encoder_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              done,
  output logic              err_illegal
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PAD, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     count_q, count_d, count_inc;
  logic                err_q, err_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                accept;

  function automatic logic is_legal(input logic [3:0] kind);
    return kind <= 4'd9;
  endfunction

  function automatic logic [31:0] encode(input logic [3:0] kind, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [15:0] imm, input logic [25:0] target);
    logic [31:0] w;
    w = 32'h0;
    case (kind)
      4'd0:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100000};
      4'd1:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100010};
      4'd2:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100100};
      4'd3:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100101};
      4'd4:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b101010};
      4'd5:    w = {6'b100011, rs, rt, imm};
      4'd6:    w = {6'b101011, rs, rt, imm};
      4'd7:    w = {6'b000100, rs, rt, imm};
      4'd8:    w = {6'b001101, rs, rt, imm};
      4'd9:    w = {6'b000010, target};
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    err_d     = err_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    count_inc = count_q + (ADDR_W+1)'(1);
    accept    = in_valid & in_ready;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LOAD;
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      S_LOAD: begin
        if (accept && is_legal(in_kind)) begin
          we_d    = 1'b1;
          addr_d  = count_q[ADDR_W-1:0];
          wdata_d = encode(in_kind, in_rs, in_rt, in_rd, in_imm, in_target);
          count_d = count_inc;
        end else if (accept) begin
          err_d = 1'b1;
        end
        // Filling the last slot wins over finish; a coinciding accept is always written first.
        if (count_d == DEPTH_C) begin
          state_d = S_DONE;
        end else if (finish) begin
`ifdef ENCODER_NOP_PAD_EN
          state_d = S_PAD;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef ENCODER_NOP_PAD_EN
      S_PAD: begin
        we_d    = 1'b1;
        addr_d  = count_q[ADDR_W-1:0];
        wdata_d = 32'h0;
        count_d = count_inc;
        if (count_inc == DEPTH_C) state_d = S_DONE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready    = (state_q == S_LOAD) && (count_q < DEPTH_C);
    busy        = (state_q == S_LOAD) || (state_q == S_PAD);
    done        = (state_q == S_DONE);
    mem_we      = we_q;
    mem_addr    = addr_q;
    mem_wdata   = wdata_q;
    word_count  = count_q;
    err_illegal = err_q;
  end

endmodule
